cnt_ctrl: RTL
=============

# cnt_ctrl

Front-end control stage for the 4-bit `cnt` counter. It synchronizes and debounces three push-buttons and a 4-bit switch bank, then produces the counter's `en`, `up`, `load` and `count_in` inputs. Each clean press becomes a single-cycle command pulse. It sits between the board I/O pins and `cnt`, with its outputs wired directly to the counter's control ports.

## Interface
- `DB_CYCLES`, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 50000000: cycles from first pulse to first auto-repeat pulse; used only with auto-repeat.
- `REPEAT_PERIOD`, 10000000: cycles between auto-repeat pulses; used only with auto-repeat.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_up` in 1: raw, asynchronous count-up button.
- `btn_down` in 1: raw, asynchronous count-down button.
- `btn_load` in 1: raw, asynchronous load button.
- `sw` in 4: raw, asynchronous load-value switches.
- `en` out 1: single-cycle count-enable pulse to `cnt`.
- `up` out 1: direction to `cnt`; 1 = increment.
- `load` out 1: single-cycle load pulse to `cnt`.
- `count_in` out 4: load value to `cnt`.

## Operation
- **Synchronizers:** each button and each `sw` bit passes through a 2-flop synchronizer. Nothing downstream uses the raw inputs.
- **Debounce (one per button):**
  - Each button has a debounced level `db` (reset 0) and a counter of width `$clog2(DB_CYCLES)`.
  - The counter clears whenever the synced level equals `db`.
  - Otherwise the counter increments. When it reaches `DB_CYCLES-1`, `db` takes the synced level and the counter clears.
  - Net effect: `db` flips after exactly `DB_CYCLES` consecutive mismatching samples. A glitch shorter than that leaves `db` unchanged.
- **Press detect:** a press is a 0→1 transition of `db`, detected against a registered copy of `db`. Releases generate nothing.
- **Command priority** (evaluated each cycle from press events):
  - Load press: `load`=1 for one cycle and `count_in` ← synced `sw`. Any up/down press in the same cycle is dropped.
  - Up press alone: `en`=1 for one cycle, `up`=1.
  - Down press alone: `en`=1 for one cycle, `up`=0.
  - Up and down press in the same cycle: no pulse, and `up` is unchanged.
- **Output holding:**
  - `en` and `load` are never high in the same cycle, and never high for two consecutive cycles except through auto-repeat spacing.
  - `up` holds the last commanded direction. `count_in` holds the last loaded value.
- **Direction FSM** (one per up/down button):
  - IDLE → on press, emit pulse and go to HELD.
  - HELD → on `db` falling, go to IDLE.
  - HELD_REPEAT exists only with auto-repeat (see Configuration).

## Timing
- **Reset values:** `en`=0, `load`=0, `up`=1, `count_in`=4'h0. All `db`=0, all counters 0, FSMs in IDLE, synchronizer flops 0.
- **Reset is asynchronous.** Asserting `rst` mid-debounce or mid-repeat immediately forces the reset values.
  - After deassertion, a button still held must complete a full debounce before it is seen as a press.
  - The press is detected because `db` restarts at 0.
- **Latency:** a raw rising edge sampled at edge 0 and held stable produces `en`/`load` high in the cycle after edge `DB_CYCLES+3`. All outputs are registered.
- **Load value:** `count_in` changes in the same cycle `load` rises and is stable from then on. `sw` is sampled through the synchronizer at the press-detect cycle.
- **Counter widths:** all counters saturate-free; they clear before overflow by construction.

## Configuration
- **`CNT_CTRL_AUTOREPEAT_EN` defined:**
  - While up or down stays debounced-high, HELD counts `REPEAT_DELAY` cycles after the initial pulse, then moves to HELD_REPEAT.
  - HELD_REPEAT emits an `en` pulse with the held direction every `REPEAT_PERIOD` cycles.
  - Release returns the FSM to IDLE.
  - If both up and down are held, no repeat pulses are emitted.
  - A load press suppresses a repeat pulse falling in the same cycle but does not reset the repeat timer.
- **Macro undefined:** exactly one `en` pulse per press. HELD_REPEAT and the repeat counters are not compiled in.

## Test plan
Benches use `DB_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.

- **Reset:** assert `rst`, then release → `en`=0, `load`=0, `up`=1, `count_in`=0 with no clock edge needed.
- **Up press:** hold `btn_up` high from edge 0 → `en`=1, `up`=1 for exactly one cycle after edge 7. Release → no further pulses.
- **Bounce rejection:** `btn_up` toggles with 2-cycle highs and 1-cycle lows for 20 cycles, then is held → exactly one `en` pulse, 7 cycles after the last low.
- **Load:** `sw`=4'hA, press `btn_load` → one `load` pulse with `count_in`=4'hA. Then `sw`=4'h3 with no press → `count_in` stays 4'hA.
- **Simultaneous presses:**
  - Up and down pressed on the same edge → no `en`, and `up` unchanged.
  - Load and down pressed on the same edge → `load` only.
- **Auto-repeat** (`CNT_CTRL_AUTOREPEAT_EN` defined): hold `btn_down` for 60 cycles → first pulse at edge 7, then pulses 20 and 25 cycles later (and so on) with `up`=0.
  - Assert `rst` mid-hold → pulses stop immediately.
  - Release `rst` with the button still held → next pulse 7 cycles later.

Source files
------------

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: button/switch front end for the 4-bit cnt counter.
//
// Synchronizes three raw push-buttons and a 4-bit switch bank, debounces each
// button, turns every clean press into a single-cycle command pulse and drives
// the counter's control inputs. All outputs are registered.
//
// Optional feature: define CNT_CTRL_AUTOREPEAT_EN to make a held up/down button
// auto-repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//
// Parameters:
//   DB_CYCLES     - consecutive stable cycles to accept a button change (>= 2)
//   REPEAT_DELAY  - cycles from first pulse to first auto-repeat pulse (>= 2)
//   REPEAT_PERIOD - cycles between auto-repeat pulses (>= 2)
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   btn_up   in  raw count-up button
//   btn_down in  raw count-down button
//   btn_load in  raw load button
//   sw       in  raw 4-bit load value switches
//   en       out single-cycle count-enable pulse
//   up       out direction, 1 = increment; holds last commanded direction
//   load     out single-cycle load pulse
//   count_in out load value; holds last loaded value
module cnt_ctrl #(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [3:0] sw,
  output logic       en,
  output logic       up,
  output logic       load,
  output logic [3:0] count_in
);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("cnt_ctrl: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
  end

  localparam int unsigned IdxUp = 0;
  localparam int unsigned IdxDn = 1;
  localparam int unsigned IdxLd = 2;

  localparam int unsigned    DbW    = $clog2(DB_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchronizers: bit 0 up, 1 down, 2 load, 6:3 switches
  // ---------------------------------------------------------------------------
  logic [6:0] meta_q;
  logic [6:0] sync_q;
  logic [2:0] btn_s;
  logic [3:0] sw_s;

  assign btn_s = sync_q[2:0];
  assign sw_s  = sync_q[6:3];

  // ---------------------------------------------------------------------------
  // Debounce and press detect
  // ---------------------------------------------------------------------------
  logic [2:0]           db_q;
  logic [2:0]           db_d;
  logic [2:0]           db_prev_q;
  logic [2:0]           press_q;
  logic [2:0][DbW-1:0]  db_cnt_q;
  logic [2:0][DbW-1:0]  db_cnt_d;

  // db flips on the DB_CYCLES-th consecutive mismatching sample; any matching
  // sample restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (btn_s[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = btn_s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      db_cnt_q  <= '0;
    end else begin
      meta_q    <= {sw, btn_load, btn_down, btn_up};
      sync_q    <= meta_q;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Direction FSMs (index 0 up, 1 down) and output register
  // ---------------------------------------------------------------------------
`ifdef CNT_CTRL_AUTOREPEAT_EN
  typedef enum logic [1:0] {StIdle, StHeld, StHeldRepeat} dir_state_e;

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                  : REPEAT_PERIOD;
  localparam int unsigned     RptW       = $clog2(RptMax);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [1:0][RptW-1:0] rpt_q;
`else
  typedef enum logic [0:0] {StIdle, StHeld} dir_state_e;
`endif

  dir_state_e state_q [2];
  logic [1:0] dir_req;
  logic       en_q;
  logic       up_q;
  logic       load_q;
  logic [3:0] count_in_q;

  // A direction request is a fresh press from IDLE or, with auto-repeat, a due
  // repeat tick while the button is still held and the other one is not.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dir_req[i] = (state_q[i] == StIdle) && press_q[i];
`ifdef CNT_CTRL_AUTOREPEAT_EN
      if (db_q[i] && !(db_q[IdxUp] && db_q[IdxDn]) &&
          (((state_q[i] == StHeld) && (rpt_q[i] == DelayLast)) ||
           ((state_q[i] == StHeldRepeat) && (rpt_q[i] == PeriodLast)))) begin
        dir_req[i] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
      end
`ifdef CNT_CTRL_AUTOREPEAT_EN
      rpt_q      <= '0;
`endif
      en_q       <= 1'b0;
      up_q       <= 1'b1;
      load_q     <= 1'b0;
      count_in_q <= 4'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          StIdle: begin
            if (press_q[i]) begin
              state_q[i] <= StHeld;
`ifdef CNT_CTRL_AUTOREPEAT_EN
              rpt_q[i]   <= '0;
`endif
            end
          end
          StHeld: begin
            if (!db_q[i]) begin
              state_q[i] <= StIdle;
            end
`ifdef CNT_CTRL_AUTOREPEAT_EN
            else if (rpt_q[i] == DelayLast) begin
              state_q[i] <= StHeldRepeat;
              rpt_q[i]   <= '0;
            end else begin
              rpt_q[i] <= rpt_q[i] + 1'b1;
            end
`endif
          end
`ifdef CNT_CTRL_AUTOREPEAT_EN
          StHeldRepeat: begin
            if (!db_q[i]) begin
              state_q[i] <= StIdle;
            end else if (rpt_q[i] == PeriodLast) begin
              rpt_q[i] <= '0;
            end else begin
              rpt_q[i] <= rpt_q[i] + 1'b1;
            end
          end
`endif
          default: state_q[i] <= StIdle;
        endcase
      end

      // Load wins over everything; opposing direction requests cancel out.
      en_q   <= 1'b0;
      load_q <= 1'b0;
      if (press_q[IdxLd]) begin
        load_q     <= 1'b1;
        count_in_q <= sw_s;
      end else if (dir_req[IdxUp] && !dir_req[IdxDn]) begin
        en_q <= 1'b1;
        up_q <= 1'b1;
      end else if (dir_req[IdxDn] && !dir_req[IdxUp]) begin
        en_q <= 1'b1;
        up_q <= 1'b0;
      end
    end
  end

  assign en       = en_q;
  assign up       = up_q;
  assign load     = load_q;
  assign count_in = count_in_q;

endmodule
